// File: rtl/stage_fifo.sv
// stage_fifo: flushable elastic buffer between two pipeline stages with visible occupancy.
// Define STAGE_FIFO_BYPASS_EN to let a beat reach the output in the same cycle when empty.
`ifndef XLEN
`define XLEN 32
`endif

module stage_fifo #(
  parameter int WIDTH = `XLEN,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     prev_stalled,
  output logic                     stall_prev,
  output logic [WIDTH-1:0]         out_data,
  output logic                     stall_next,
  input  logic                     next_stalled,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;

  logic empty;
  logic full;
  logic bypass;
  logic push;
  logic pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (PW+1)'(DEPTH));

`ifdef STAGE_FIFO_BYPASS_EN
  assign bypass = empty && !prev_stalled && !flush && !rst;
`else
  assign bypass = 1'b0;
`endif

  // stall_prev only looks at occupancy, so a full FIFO refuses input even while popping.
  assign stall_prev = rst || full;
  assign stall_next = rst || (empty && !bypass);

  assign pop  = !stall_next && !next_stalled && !flush && !empty;
  assign push = !prev_stalled && !stall_prev && !flush && !(bypass && !next_stalled);

  assign out_data = stall_next ? '0 : (empty ? in_data : mem_reg[rd_ptr_reg]);
  assign count    = count_reg;

  // Storage is not reset or cleared by flush; count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_fifo.sv
// Self-checking bench for stage_fifo: DEPTH=4 and DEPTH=2 instances share stimulus
// and are compared against queue-based reference models (bypass follows STAGE_FIFO_BYPASS_EN).
`timescale 1ns/1ps
`ifndef XLEN
`define XLEN 32
`endif

module tb_stage_fifo;
  localparam int W = 32;
`ifdef STAGE_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
  localparam int LAT = 0;
`else
  localparam bit BYP = 1'b0;
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         prev_stalled = 1'b1;
  logic         next_stalled = 1'b1;
  logic [W-1:0] in_data = '0;

  logic [W-1:0] out4, out2;
  logic         sp4, sn4, sp2, sn2;
  logic [2:0]   count4;
  logic [1:0]   count2;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] q4[$];
  logic [W-1:0] q2[$];

  always #5 clk = ~clk;

  stage_fifo #(.WIDTH(W), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data),
    .prev_stalled(prev_stalled), .stall_prev(sp4), .out_data(out4),
    .stall_next(sn4), .next_stalled(next_stalled), .count(count4)
  );

  stage_fifo #(.WIDTH(W), .DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data),
    .prev_stalled(prev_stalled), .stall_prev(sp2), .out_data(out2),
    .stall_next(sn2), .next_stalled(next_stalled), .count(count2)
  );

  // Reference rules, evaluated on the current inputs and model occupancy.
  function automatic bit byp_act(int sz);
    return BYP && sz == 0 && !prev_stalled && !flush && !rst;
  endfunction

  function automatic bit exp_sn(int sz);
    return rst || (sz == 0 && !byp_act(sz));
  endfunction

  function automatic bit exp_sp(int sz, int d);
    return rst || sz == d;
  endfunction

  function automatic logic [W-1:0] exp_out(int sz, logic [W-1:0] head);
    if (exp_sn(sz)) return '0;
    return (sz > 0) ? head : in_data;
  endfunction

  always @(posedge clk) begin
    bit pop4, push4, pop2, push2;
    if (rst || flush) begin
      q4.delete();
      q2.delete();
    end else begin
      pop4  = !exp_sn(q4.size()) && !next_stalled && q4.size() > 0;
      push4 = !prev_stalled && !exp_sp(q4.size(), 4) && !(byp_act(q4.size()) && !next_stalled);
      pop2  = !exp_sn(q2.size()) && !next_stalled && q2.size() > 0;
      push2 = !prev_stalled && !exp_sp(q2.size(), 2) && !(byp_act(q2.size()) && !next_stalled);
      if (pop4) void'(q4.pop_front());
      if (push4) q4.push_back(in_data);
      if (pop2) void'(q2.pop_front());
      if (push2) q2.push_back(in_data);
    end
  end

  task automatic cyc(input logic r, input logic ps, input logic ns, input logic fl,
                     input logic [W-1:0] d);
    @(negedge clk);
    rst = r;
    prev_stalled = ps;
    next_stalled = ns;
    flush = fl;
    in_data = d;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 1, 0, '0);
      vectors++;
      if ({sp4, sn4, sp2, sn2} !== 4'b1111) begin
        miscompares++;
        $display("FAIL reset_hold: stalls=%b required 1111", {sp4, sn4, sp2, sn2});
      end
    end
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 1, 0, 32'hDEAD_BEEF);
      vectors++;
      if (count4 !== 3'd0 || sp4 !== 1'b0 || sn4 !== 1'b1 || out4 !== '0) begin
        miscompares++;
        $display("FAIL reset_idle4 c%0d: count=%0d sp=%b sn=%b out=%h required 0 0 1 0",
                 i, count4, sp4, sn4, out4);
      end
      vectors++;
      if (count2 !== 2'd0 || sp2 !== 1'b0 || sn2 !== 1'b1 || out2 !== '0) begin
        miscompares++;
        $display("FAIL reset_idle2 c%0d: count=%0d sp=%b sn=%b out=%h required 0 0 1 0",
                 i, count2, sp2, sn2, out2);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    cyc(0, 1, 1, 1, '0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 32'h11 * (i + 1));
    cyc(0, 0, 1, 0, 32'h55);
    vectors++;
    if (count4 !== 3'd4 || sp4 !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_full: count=%0d sp=%b required 4 1", count4, sp4);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 0, '0);
      vectors++;
      if (sn4 !== 1'b0 || out4 !== 32'h11 * (i + 1)) begin
        miscompares++;
        $display("FAIL drain_%0d: sn=%b out=%h required 0 %h", i, sn4, out4, 32'h11 * (i + 1));
      end
    end
    cyc(0, 1, 0, 0, '0);
    vectors++;
    if (sn4 !== 1'b1 || count4 !== 3'd0 || out4 !== '0) begin
      miscompares++;
      $display("FAIL drain_empty: sn=%b count=%0d out=%h required 1 0 0", sn4, count4, out4);
    end
    $display("test_fill_drain done");
  endtask

  task automatic test_streaming();
    logic [W-1:0] got[$];
    int first = -1;
    int last = -1;
    cyc(0, 1, 1, 1, '0);
    for (int c = 0; c < 12; c++) begin
      cyc(0, (c >= 10), 0, 0, W'(c));
      if (!sn2) begin
        got.push_back(out2);
        if (first < 0) first = c;
        last = c;
      end
      vectors++;
      if (count2 > 2'd1) begin
        miscompares++;
        $display("FAIL stream_count c%0d: count=%0d required <=1", c, count2);
      end
    end
    vectors++;
    if (got.size() != 10) begin
      miscompares++;
      $display("FAIL stream_len: got %0d beats required 10", got.size());
    end
    for (int i = 0; i < got.size() && i < 10; i++) begin
      vectors++;
      if (got[i] !== W'(i)) begin
        miscompares++;
        $display("FAIL stream_data_%0d: out=%h required %h", i, got[i], W'(i));
      end
    end
    vectors++;
    if (first != LAT || last - first != 9) begin
      miscompares++;
      $display("FAIL stream_timing: first=%0d span=%0d required %0d 9", first, last - first, LAT);
    end
    $display("test_streaming done");
  endtask

  task automatic test_flush();
    cyc(0, 1, 1, 1, '0);
    for (int i = 1; i <= 3; i++) cyc(0, 0, 1, 0, W'(i));
    cyc(0, 0, 1, 1, 32'hAA);
    vectors++;
    if (count4 !== 3'd3 || sn4 !== 1'b0 || out4 !== 32'h1) begin
      miscompares++;
      $display("FAIL flush_cycle: count=%0d sn=%b out=%h required 3 0 1", count4, sn4, out4);
    end
    cyc(0, 1, 1, 0, '0);
    vectors++;
    if (count4 !== 3'd0 || sn4 !== 1'b1 || out4 !== '0) begin
      miscompares++;
      $display("FAIL flush_after: count=%0d sn=%b out=%h required 0 1 0", count4, sn4, out4);
    end
    cyc(0, 0, 1, 0, 32'hBB);
    cyc(0, 1, 0, 0, '0);
    vectors++;
    if (sn4 !== 1'b0 || out4 !== 32'hBB) begin
      miscompares++;
      $display("FAIL flush_next: sn=%b out=%h required 0 bb", sn4, out4);
    end
    cyc(0, 1, 0, 0, '0);
    vectors++;
    if (sn4 !== 1'b1 || count4 !== 3'd0) begin
      miscompares++;
      $display("FAIL flush_drained: sn=%b count=%0d required 1 0", sn4, count4);
    end
    $display("test_flush done");
  endtask

  task automatic test_back_to_back();
    cyc(0, 1, 1, 1, '0);
    cyc(0, 0, 1, 0, 32'h31);
    cyc(0, 0, 1, 0, 32'h32);
    for (int k = 0; k < 6; k++) begin
      cyc(0, 0, 0, 0, 32'h33 + k);
      vectors++;
      if (count4 !== 3'd2 || sp4 !== 1'b0 || out4 !== 32'h31 + k) begin
        miscompares++;
        $display("FAIL b2b_%0d: count=%0d sp=%b out=%h required 2 0 %h",
                 k, count4, sp4, out4, 32'h31 + k);
      end
    end
    for (int k = 0; k < 2; k++) begin
      cyc(0, 1, 0, 0, '0);
      vectors++;
      if (sn4 !== 1'b0 || out4 !== 32'h37 + k) begin
        miscompares++;
        $display("FAIL b2b_tail_%0d: sn=%b out=%h required 0 %h", k, sn4, out4, 32'h37 + k);
      end
    end
    $display("test_back_to_back done");
  endtask

`ifdef STAGE_FIFO_BYPASS_EN
  task automatic test_bypass();
    cyc(0, 1, 1, 1, '0);
    cyc(0, 0, 0, 0, 32'h77);
    vectors++;
    if (sn4 !== 1'b0 || out4 !== 32'h77 || count4 !== 3'd0) begin
      miscompares++;
      $display("FAIL bypass_pass: sn=%b out=%h count=%0d required 0 77 0", sn4, out4, count4);
    end
    cyc(0, 1, 0, 0, '0);
    vectors++;
    if (sn4 !== 1'b1 || count4 !== 3'd0) begin
      miscompares++;
      $display("FAIL bypass_gone: sn=%b count=%0d required 1 0", sn4, count4);
    end
    cyc(0, 0, 1, 0, 32'h77);
    vectors++;
    if (sn4 !== 1'b0 || out4 !== 32'h77) begin
      miscompares++;
      $display("FAIL bypass_stalled: sn=%b out=%h required 0 77", sn4, out4);
    end
    cyc(0, 1, 1, 0, '0);
    vectors++;
    if (count4 !== 3'd1 || out4 !== 32'h77) begin
      miscompares++;
      $display("FAIL bypass_stored: count=%0d out=%h required 1 77", count4, out4);
    end
    $display("test_bypass done");
  endtask
`endif

  task automatic test_random();
    int s4, s2;
    logic [W-1:0] h4, h2;
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), W'($urandom));
      s4 = q4.size();
      s2 = q2.size();
      h4 = (s4 > 0) ? q4[0] : '0;
      h2 = (s2 > 0) ? q2[0] : '0;
      vectors++;
      if (count4 !== 3'(s4)) begin
        miscompares++;
        $display("FAIL rnd_count4 %0d: got %0d required %0d", i, count4, s4);
      end
      vectors++;
      if (sp4 !== exp_sp(s4, 4) || sn4 !== exp_sn(s4)) begin
        miscompares++;
        $display("FAIL rnd_stall4 %0d: sp/sn=%b%b required %b%b", i, sp4, sn4, exp_sp(s4, 4), exp_sn(s4));
      end
      vectors++;
      if (out4 !== exp_out(s4, h4)) begin
        miscompares++;
        $display("FAIL rnd_out4 %0d: got %h required %h", i, out4, exp_out(s4, h4));
      end
      vectors++;
      if (count2 !== 2'(s2)) begin
        miscompares++;
        $display("FAIL rnd_count2 %0d: got %0d required %0d", i, count2, s2);
      end
      vectors++;
      if (sp2 !== exp_sp(s2, 2) || sn2 !== exp_sn(s2)) begin
        miscompares++;
        $display("FAIL rnd_stall2 %0d: sp/sn=%b%b required %b%b", i, sp2, sn2, exp_sp(s2, 2), exp_sn(s2));
      end
      vectors++;
      if (out2 !== exp_out(s2, h2)) begin
        miscompares++;
        $display("FAIL rnd_out2 %0d: got %h required %h", i, out2, exp_out(s2, h2));
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_flush();
    test_back_to_back();
`ifdef STAGE_FIFO_BYPASS_EN
    test_bypass();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
